// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: shared state encodings, port IDs and the round-robin pick for the memory port arbiter
// Contents: ARB_* controller state constants, PORT_* requester IDs, pick_winner() grant selection.
package mem_port_arbiter_pkg;
    localparam logic [1:0] ARB_IDLE = 2'd0;
    localparam logic [1:0] ARB_WAIT = 2'd1;
    localparam logic [1:0] ARB_DONE = 2'd2;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_LDR = 1'b1;

    // With both ports requesting, the port that did not own the last grant wins.
    function automatic logic pick_winner(input logic req0, input logic req1, input logic owner);
        return (req0 && req1) ? ~owner : (req0 ? PORT_CPU : PORT_LDR);
    endfunction
endpackage

// File: rtl/mem_port_arbiter_lat_counter.sv
// lat_counter: loadable down-counter that stops at zero and flags it
// Ports: i_clk clock; i_rst_n sync active-low reset; i_load/i_value load a new count;
//        i_dec decrement by one; o_zero high while the count is zero.
module lat_counter #(
    parameter int CNT_W = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_value,
    input  logic             i_dec,
    output logic             o_zero
);
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n)
            r_cnt <= '0;
        else if (i_load)
            r_cnt <= i_value;
        else if (i_dec && r_cnt != '0)
            r_cnt <= r_cnt - 1'b1;
    end

    assign o_zero = (r_cnt == '0);
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin sharing of one memory port between the CPU (port 0) and the loader/debug port (port 1)
// Ports: i_clk clock; i_rst_n sync active-low reset;
//        i_reqN/i_weN/i_addrN/i_wdataN one transaction request from port N, held until o_doneN;
//        o_doneN one-cycle completion pulse, o_rdataN read data valid while o_doneN;
//        o_mem_en/o_mem_we/o_mem_addr/o_mem_wdata memory strobe, write enable, address, write data; i_mem_rdata read data;
//        o_busy high outside IDLE; o_owner port of the current or last grant.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 2,
    parameter int CNT_W   = 4
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_req0,
    input  logic              i_we0,
    input  logic [ADDR_W-1:0] i_addr0,
    input  logic [DATA_W-1:0] i_wdata0,
    output logic              o_done0,
    output logic [DATA_W-1:0] o_rdata0,
    input  logic              i_req1,
    input  logic              i_we1,
    input  logic [ADDR_W-1:0] i_addr1,
    input  logic [DATA_W-1:0] i_wdata1,
    output logic              o_done1,
    output logic [DATA_W-1:0] o_rdata1,
    output logic              o_mem_en,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    input  logic [DATA_W-1:0] i_mem_rdata,
    output logic              o_busy,
    output logic              o_owner
);
    if (MEM_LAT < 1 || MEM_LAT > 15 || MEM_LAT > (1 << CNT_W)) begin : g_bad_lat
        $error("mem_port_arbiter: MEM_LAT must be 1..15 and fit in CNT_W bits");
    end

    logic [1:0]        r_state;
    logic [1:0]        w_next;
    logic              r_owner;
    logic              r_busy;
    logic              r_done0;
    logic              r_done1;
    logic              r_mem_en;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic [DATA_W-1:0] r_rdata0;
    logic [DATA_W-1:0] r_rdata1;
    logic              w_grant;
    logic              w_win;
    logic              w_win_we;
    logic              w_zero;
    logic              w_finish;
    logic              w_next_owner;

    assign w_grant      = (r_state == ARB_IDLE) && (i_req0 || i_req1);
    assign w_win        = pick_winner(i_req0, i_req1, r_owner);
    assign w_win_we     = w_win ? i_we1 : i_we0;
    assign w_finish     = (r_state == ARB_WAIT) && w_zero;
    assign w_next_owner = w_grant ? w_win : r_owner;

    // Writes complete at the grant; reads wait MEM_LAT cycles counted down from MEM_LAT-1.
    always_comb
        w_next = (r_state == ARB_IDLE) ? (w_grant ? (w_win_we ? ARB_DONE : ARB_WAIT) : ARB_IDLE) :
                 (r_state == ARB_WAIT) ? (w_zero ? ARB_DONE : ARB_WAIT) : ARB_IDLE;

    lat_counter #(.CNT_W(CNT_W)) u_lat (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_load  (w_grant && !w_win_we),
        .i_value (CNT_W'(MEM_LAT - 1)),
        .i_dec   (r_state == ARB_WAIT),
        .o_zero  (w_zero)
    );

    // done and busy are registered from the next state so done is high exactly while in DONE.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state     <= ARB_IDLE;
            r_owner     <= PORT_LDR;
            r_busy      <= 1'b0;
            r_done0     <= 1'b0;
            r_done1     <= 1'b0;
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_rdata0    <= '0;
            r_rdata1    <= '0;
        end else begin
            r_state  <= w_next;
            r_owner  <= w_next_owner;
            r_busy   <= (w_next != ARB_IDLE);
            r_done0  <= (w_next == ARB_DONE) && (w_next_owner == PORT_CPU);
            r_done1  <= (w_next == ARB_DONE) && (w_next_owner == PORT_LDR);
            r_mem_en <= w_grant;
            r_mem_we <= w_grant && w_win_we;
            if (w_grant) begin
                r_mem_addr  <= w_win ? i_addr1 : i_addr0;
                r_mem_wdata <= w_win ? i_wdata1 : i_wdata0;
            end
            if (w_finish && r_owner == PORT_CPU)
                r_rdata0 <= i_mem_rdata;
            if (w_finish && r_owner == PORT_LDR)
                r_rdata1 <= i_mem_rdata;
        end
    end

    assign o_done0     = r_done0;
    assign o_done1     = r_done1;
    assign o_rdata0    = r_rdata0;
    assign o_rdata1    = r_rdata1;
    assign o_mem_en    = r_mem_en;
    assign o_mem_we    = r_mem_we;
    assign o_mem_addr  = r_mem_addr;
    assign o_mem_wdata = r_mem_wdata;
    assign o_busy      = r_busy;
    assign o_owner     = r_owner;
endmodule
